// File: rtl/lii_pkg.sv
// Shared constants and sizing helpers for the LII stream adapter family.
package lii_pkg;

    localparam int LII_ROUTE_W = 8;

    function automatic int lii_beats(input int w, input int pw);
        return (w + pw - 1) / pw;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int lii_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Synchronous FIFO with registered full/empty/free flags; a full FIFO refuses
// any push even when a pop happens in the same cycle.
module lii_sync_fifo
    import lii_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [lii_cw(DEPTH+1)-1:0] free
);

    localparam int AW = lii_cw(DEPTH);
    localparam int CW = lii_cw(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          full_r;
    logic          empty_r;
    logic [CW-1:0] free_r;
    logic          push_s;
    logic          pop_s;

    assign push_s  = wr_en & ~full_r;
    assign pop_s   = rd_en & ~empty_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign free    = free_r;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            free_r   <= CW'(DEPTH);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? '0 : wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? '0 : rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            empty_r <= (count_nxt_s == '0);
            free_r  <= CW'(DEPTH) - count_nxt_s;
        end
    end

endmodule

// File: rtl/lii_stream_adapter.sv
// Bridges one LII phy channel pair to a kernel stream pair: gathers narrow
// beats into kernel words, buffers kernel results and splits them into beats.
module lii_stream_adapter
    import lii_pkg::*;
#(
    parameter int PW       = 1024,
    parameter int KIW      = 1024,
    parameter int KOW      = 192,
    parameter int DEPTH    = 4,
    parameter int CE_SLACK = 1,
    parameter logic [LII_ROUTE_W-1:0] SRC_ID = 8'h00,
    parameter logic [LII_ROUTE_W-1:0] DST_ID = 8'h00
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic [PW-1:0]          lii_in_p0_tdata,
    input  logic                   lii_in_p0_tvalid,
    output logic                   lii_in_p0_tready,
    input  logic [LII_ROUTE_W-1:0] lii_in_p0_src,
    input  logic [LII_ROUTE_W-1:0] lii_in_p0_dst,
    output logic [PW-1:0]          lii_out_p0_tdata,
    output logic                   lii_out_p0_tvalid,
    input  logic                   lii_out_p0_tready,
    output logic [LII_ROUTE_W-1:0] lii_out_p0_src,
    output logic [LII_ROUTE_W-1:0] lii_out_p0_dst,
    output logic [KIW-1:0]         in_stream_tdata,
    output logic                   in_stream_tvalid,
    input  logic                   in_stream_tready,
    input  logic [KOW-1:0]         out_stream_tdata,
    input  logic                   out_stream_tvalid,
    output logic                   out_stream_tready,
    output logic                   ce
);

    localparam int IN_BEATS  = lii_beats(KIW, PW);
    localparam int OUT_BEATS = lii_beats(KOW, PW);
    localparam int ICW       = lii_cw(IN_BEATS);
    localparam int OCW       = lii_cw(OUT_BEATS);
    localparam int FCW       = lii_cw(DEPTH + 1);

    logic [IN_BEATS*PW-1:0]  word_r;
    logic [ICW-1:0]          in_cnt_r;
    logic                    in_valid_r;
    logic                    in_acc_s;
    logic                    in_last_s;
    logic [OCW-1:0]          out_cnt_r;
    logic                    out_acc_s;
    logic                    out_last_s;
    logic [KOW-1:0]          head_s;
    logic [OUT_BEATS*PW-1:0] out_word_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [FCW-1:0]          fifo_free_s;
    logic                    unused_route_s;

    assign unused_route_s    = ^{lii_in_p0_src, lii_in_p0_dst};
    assign lii_out_p0_src    = SRC_ID;
    assign lii_out_p0_dst    = DST_ID;

    assign lii_in_p0_tready  = ~in_valid_r | in_stream_tready;
    assign in_acc_s          = lii_in_p0_tvalid & lii_in_p0_tready;
    assign in_last_s         = (in_cnt_r == ICW'(IN_BEATS - 1));
    assign in_stream_tvalid  = in_valid_r;
    assign in_stream_tdata   = word_r[KIW-1:0];

    assign out_stream_tready = ~fifo_full_s;
    assign lii_out_p0_tvalid = ~fifo_empty_s;
    assign out_acc_s         = lii_out_p0_tvalid & lii_out_p0_tready;
    assign out_last_s        = (out_cnt_r == OCW'(OUT_BEATS - 1));
    assign ce                = (fifo_free_s >= FCW'(CE_SLACK)) & lii_in_p0_tready;

    // Gather phy beats LSB-first into the kernel word; hold it until consumed.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            word_r     <= '0;
            in_cnt_r   <= '0;
            in_valid_r <= 1'b0;
        end else begin
            if (in_acc_s) begin
                word_r[in_cnt_r*PW +: PW] <= lii_in_p0_tdata;
                in_cnt_r <= in_last_s ? '0 : in_cnt_r + ICW'(1);
            end
            if (in_acc_s && in_last_s) begin
                in_valid_r <= 1'b1;
            end else if (in_stream_tready) begin
                in_valid_r <= 1'b0;
            end
        end
    end

    lii_sync_fifo #(
        .W     (KOW),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk     (aclk),
        .rst     (arst),
        .wr_data (out_stream_tdata),
        .wr_en   (out_stream_tvalid),
        .rd_en   (out_acc_s & out_last_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .free    (fifo_free_s)
    );

    // Select the current beat of the zero-padded head word.
    always_comb begin
        out_word_s             = '0;
        out_word_s[KOW-1:0]    = head_s;
        lii_out_p0_tdata       = out_word_s[out_cnt_r*PW +: PW];
    end

    // Split counter advances per accepted beat and wraps with the pop.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            out_cnt_r <= '0;
        end else if (out_acc_s) begin
            out_cnt_r <= out_last_s ? '0 : out_cnt_r + OCW'(1);
        end
    end

endmodule

// File: tb/tb_lii_stream_adapter.sv
// Directed bench for lii_stream_adapter with 64-bit beats, 4-beat input
// words and 3-beat output words.
module tb_lii_stream_adapter;

    localparam int PW  = 64;
    localparam int KIW = 256;
    localparam int KOW = 192;

    logic           aclk;
    logic           arst;
    logic [PW-1:0]  in_tdata;
    logic           in_tvalid;
    logic           in_tready;
    logic [7:0]     in_src;
    logic [7:0]     in_dst;
    logic [PW-1:0]  out_tdata;
    logic           out_tvalid;
    logic           out_tready;
    logic [7:0]     out_src;
    logic [7:0]     out_dst;
    logic [KIW-1:0] k_in_tdata;
    logic           k_in_tvalid;
    logic           k_in_tready;
    logic [KOW-1:0] k_out_tdata;
    logic           k_out_tvalid;
    logic           k_out_tready;
    logic           ce;

    int n_tests = 0;
    int n_fail  = 0;

    lii_stream_adapter #(
        .PW(PW), .KIW(KIW), .KOW(KOW), .DEPTH(4), .CE_SLACK(1),
        .SRC_ID(8'h5A), .DST_ID(8'hC3)
    ) dut (
        .aclk              (aclk),
        .arst              (arst),
        .lii_in_p0_tdata   (in_tdata),
        .lii_in_p0_tvalid  (in_tvalid),
        .lii_in_p0_tready  (in_tready),
        .lii_in_p0_src     (in_src),
        .lii_in_p0_dst     (in_dst),
        .lii_out_p0_tdata  (out_tdata),
        .lii_out_p0_tvalid (out_tvalid),
        .lii_out_p0_tready (out_tready),
        .lii_out_p0_src    (out_src),
        .lii_out_p0_dst    (out_dst),
        .in_stream_tdata   (k_in_tdata),
        .in_stream_tvalid  (k_in_tvalid),
        .in_stream_tready  (k_in_tready),
        .out_stream_tdata  (k_out_tdata),
        .out_stream_tvalid (k_out_tvalid),
        .out_stream_tready (k_out_tready),
        .ce                (ce)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic send_beat(input logic [63:0] d);
        in_tdata  = d;
        in_tvalid = 1'b1;
        tick();
        in_tvalid = 1'b0;
    endtask

    task automatic push_word(input logic [191:0] w);
        k_out_tdata  = w;
        k_out_tvalid = 1'b1;
        tick();
        k_out_tvalid = 1'b0;
    endtask

    logic [191:0] w0;
    logic [191:0] fw [5];
    logic [11:0]  pat;
    int           idx;

    initial begin
        arst = 1'b1;
        in_tdata = '0; in_tvalid = 1'b0; in_src = 8'h01; in_dst = 8'h02;
        out_tready = 1'b0; k_in_tready = 1'b1;
        k_out_tdata = '0; k_out_tvalid = 1'b0;
        w0 = {rep(8'hAA), rep(8'hBB), rep(8'hCC)};
        for (int k = 0; k < 5; k++)
            fw[k] = {rep(8'(16*k + 3)), rep(8'(16*k + 2)), rep(8'(16*k + 1))};
        pat = 12'b0000_1101_0100;

        tick(); tick();
        check("rst_in_valid", k_in_tvalid, 0);
        check("rst_out_valid", out_tvalid, 0);
        check("rst_in_tready", in_tready, 1);
        check("rst_k_out_tready", k_out_tready, 1);
        check("rst_ce", ce, 1);
        check("rst_word", k_in_tdata, 0);
        check("route", {out_src, out_dst}, 16'h5AC3);
        arst = 1'b0;
        tick();

        // Gather with kernel always ready.
        send_beat(rep(8'h11)); check("g_b1_valid", k_in_tvalid, 0);
        send_beat(rep(8'h22)); check("g_b2_valid", k_in_tvalid, 0);
        send_beat(rep(8'h33)); check("g_b3_valid", k_in_tvalid, 0);
        send_beat(rep(8'h44)); check("g_valid", k_in_tvalid, 1);
        check("g_word", k_in_tdata, {rep(8'h44), rep(8'h33), rep(8'h22), rep(8'h11)});
        tick(); check("g_consumed", k_in_tvalid, 0);

        // Kernel stall: word held, phy input back-pressured.
        k_in_tready = 1'b0;
        send_beat(rep(8'h55)); send_beat(rep(8'h66));
        send_beat(rep(8'h77)); send_beat(rep(8'h88));
        check("s_valid", k_in_tvalid, 1);
        in_tdata = rep(8'h99); in_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("s_in_tready", in_tready, 0);
            check("s_ce", ce, 0);
            check("s_word", k_in_tdata, {rep(8'h88), rep(8'h77), rep(8'h66), rep(8'h55)});
            tick();
        end
        k_in_tready = 1'b1;
        #1;
        check("s_release_tready", in_tready, 1);
        tick();
        in_tvalid = 1'b0;
        send_beat(rep(8'hAA)); send_beat(rep(8'hBB)); send_beat(rep(8'hCC));
        check("s_next_valid", k_in_tvalid, 1);
        check("s_next_word", k_in_tdata, {rep(8'hCC), rep(8'hBB), rep(8'hAA), rep(8'h99)});
        tick();

        // Split one result into three beats under irregular ready.
        out_tready = 1'b0;
        push_word(w0);
        check("sp_valid", out_tvalid, 1);
        check("sp_first", out_tdata, rep(8'hCC));
        idx = 0;
        for (int i = 0; i < 12 && idx < 3; i++) begin
            out_tready = pat[i];
            #1;
            check("sp_beat", out_tdata, w0[idx*64 +: 64]);
            check("sp_hold_valid", out_tvalid, 1);
            tick();
            if (pat[i]) idx++;
        end
        check("sp_beats", idx, 3);
        check("sp_popped", out_tvalid, 0);
        out_tready = 1'b0;

        // Fill, then pop from full while the kernel pushes.
        push_word(fw[0]); push_word(fw[1]); push_word(fw[2]);
        check("f3_k_tready", k_out_tready, 1);
        check("f3_ce", ce, 1);
        push_word(fw[3]);
        check("f4_k_tready", k_out_tready, 0);
        check("f4_ce", ce, 0);
        out_tready = 1'b1;
        tick(); tick();
        k_out_tdata = fw[4]; k_out_tvalid = 1'b1;
        #1;
        check("full_refuse", k_out_tready, 0);
        tick();
        check("after_pop_tready", k_out_tready, 1);
        out_tready = 1'b0;
        tick();
        k_out_tvalid = 1'b0;
        check("refill_full", k_out_tready, 0);
        out_tready = 1'b1;
        for (int w = 1; w < 5; w++) begin
            for (int b = 0; b < 3; b++) begin
                check("drain_valid", out_tvalid, 1);
                check("drain_beat", out_tdata, fw[w][b*64 +: 64]);
                tick();
            end
        end
        check("drain_empty", out_tvalid, 0);
        out_tready = 1'b0;

        // Reset mid-gather and mid-output-word.
        send_beat(rep(8'hDD)); send_beat(rep(8'hEE));
        push_word(fw[0]);
        out_tready = 1'b1; tick(); out_tready = 1'b0;
        check("pre_rst_out_valid", out_tvalid, 1);
        #2 arst = 1'b1;
        #1;
        check("arst_out_valid", out_tvalid, 0);
        check("arst_in_valid", k_in_tvalid, 0);
        check("arst_in_tready", in_tready, 1);
        tick();
        arst = 1'b0;
        send_beat(rep(8'h01)); send_beat(rep(8'h02));
        send_beat(rep(8'h03)); send_beat(rep(8'h04));
        check("post_rst_valid", k_in_tvalid, 1);
        check("post_rst_word", k_in_tdata, {rep(8'h04), rep(8'h03), rep(8'h02), rep(8'h01)});
        check("post_rst_out_valid", out_tvalid, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lii_stream_adapter.md
# lii_stream_adapter

Parametrised successor of the per-kernel LII stream wrappers. It connects one HLS kernel stream pair to one LII physical input channel and one LII physical output channel. Unlike the single-beat pass-through wrappers, it gathers several narrow phy beats into one wide kernel word, splits wide kernel results into several phy beats, and buffers kernel results in a FIFO. It also stamps route fields and drives the kernel clock enable from buffer headroom instead of from raw handshake signals.

## Interface
- PW, 1024: phy packing width (bits per LII beat).
- KIW, 1024: kernel input word width; IN_BEATS = ceil(KIW/PW).
- KOW, 192: kernel output word width; OUT_BEATS = ceil(KOW/PW).
- DEPTH, 4: output FIFO depth in kernel words, ≥2.
- CE_SLACK, 1: free FIFO entries required to keep ce high, 1..DEPTH.
- SRC_ID, 8'h00: value driven on lii_out_p0_src.
- DST_ID, 8'h00: value driven on lii_out_p0_dst.
- aclk  in  1  clock, rising edge.
- arst  in  1  asynchronous, active-high reset.
- lii_in_p0_tdata  in  PW  phy input beat.
- lii_in_p0_tvalid  in  1  beat valid.
- lii_in_p0_tready  out  1  beat accepted when high with tvalid.
- lii_in_p0_src / lii_in_p0_dst  in  8 each  route fields; ignored.
- lii_out_p0_tdata  out  PW  phy output beat.
- lii_out_p0_tvalid  out  1  beat valid.
- lii_out_p0_tready  in  1  downstream ready.
- lii_out_p0_src / lii_out_p0_dst  out  8 each  constant SRC_ID / DST_ID.
- in_stream_tdata  out  KIW  assembled kernel input word.
- in_stream_tvalid  out  1  word valid.
- in_stream_tready  in  1  kernel accepts the word.
- out_stream_tdata  in  KOW  kernel result word.
- out_stream_tvalid  in  1  result valid.
- out_stream_tready  out  1  FIFO not full.
- ce  out  1  kernel clock enable.

## Operation
- Gather: the input beat counter runs 0..IN_BEATS-1. Beat k loads bits [k·PW +: PW] of the word register, so beat 0 is the LSBs. Bits above KIW are discarded.
- On acceptance of the final beat: the counter wraps to 0 and in_stream_tvalid is set.
- in_stream_tvalid holds, with stable data, until in_stream_tready.
- lii_in_p0_tready = !in_stream_tvalid | in_stream_tready. Beat 0 of the next word may be accepted in the same cycle the kernel consumes the current word.
- Output FIFO: a push is out_stream_tvalid & out_stream_tready, where out_stream_tready = !full. A full FIFO does not pass through a simultaneous pop.
- Split: the head word is emitted as OUT_BEATS beats, beat j = bits [j·PW +: PW], LSBs first. Bits above KOW are zero-padded.
- The split counter advances on each lii_out_p0_tvalid & lii_out_p0_tready. The FIFO pops on acceptance of beat OUT_BEATS-1.
- lii_out_p0_tvalid = !empty. Data, valid and beat index stay stable while stalled.
- ce = (free entries ≥ CE_SLACK) & (!in_stream_tvalid | in_stream_tready).
- Reset values:
  - All tvalid outputs 0; counters 0; FIFO empty.
  - lii_in_p0_tready = 1, out_stream_tready = 1, ce = 1.
  - Data registers 0.
- Reset mid-word discards partial gathers, FIFO contents and any partially sent output word. No recovery is attempted.

## Timing
- Input latency: final beat accepted at edge t, in_stream_tvalid = 1 after edge t.
- Throughput: one kernel word per IN_BEATS cycles, sustained when the kernel is always ready.
- Output latency: push at edge t, first beat valid after edge t (registered FIFO, no bypass).
- Output throughput: one phy beat per cycle with continuous lii_out_p0_tready.
- Full and empty flags and the free-entry count are registered. ce and the tready outputs are combinational from registers and the inputs listed above.
- A simultaneous push and pop leaves the count unchanged. This is legal at every count except full, where no push is accepted.

## Structure
- Package lii_pkg holds:
  - LII_ROUTE_W = 8.
  - Function lii_beats(w, pw) = (w+pw-1)/pw.
  - A counter-width helper.
- Sub-module lii_sync_fifo: parametrised width and depth, registered full/empty/count, asynchronous active-high reset.
- The gather and split logic stays inline in lii_stream_adapter.

## Test plan
- PW=256, KIW=1024: send beats 0x11..,0x22..,0x33..,0x44.. with the kernel ready -> one in_stream word {0x44..,0x33..,0x22..,0x11..}, valid the cycle after beat 4.
- PW=1024, KOW=192, DEPTH=4, lii_out_p0_tready held low: push 4 words -> out_stream_tready = 0 after the 4th push. With CE_SLACK=1, ce = 0 after the 4th push.
- PW=64, KOW=192: push 0xAAA…_BBB…_CCC… -> 3 beats, LSB first, each held stable under random tready. Pop occurs only after the 3rd beat is accepted.
- Kernel stalls in_stream_tready for 5 cycles with the word valid -> lii_in_p0_tready = 0 throughout. The word is held stable and no beat is lost.
- Assert arst after 2 of 4 input beats and mid-output-word -> all tvalid outputs 0 immediately. After release, a fresh 4-beat sequence assembles correctly.
- Full FIFO with simultaneous pop and kernel push -> the push is refused that cycle and accepted the next cycle. Word order is preserved.
